modn_cascade_counter: RTL



---
 rtl/modn_cascade_counter.sv | 106 ++++++++++
 1 files changed

// File: rtl/modn_cascade_counter.sv
// modn_cascade_counter
//   Parametrised multi-digit modulo up/down counter built from DIGITS
//   cascaded digits of DIGIT_W bits each. Digit 0 is least significant.
//   A modulus of ten per digit yields a BCD counter.
//   Optional saturating behaviour is selected by the MODN_SAT_EN macro,
//   which adds the sat_mode port.

module modn_cascade_counter #(
  parameter int DIGIT_W = 4,
  parameter int MOD     = 10,
  parameter int DIGITS  = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      en,
  input  logic                      up_dn,
  input  logic                      load,
  input  logic [DIGITS*DIGIT_W-1:0] load_val,
`ifdef MODN_SAT_EN
  input  logic                      sat_mode,
`endif
  output logic [DIGITS*DIGIT_W-1:0] q,
  output logic                      tc,
  output logic                      wrap
);

  generate
    if (MOD < 2 || MOD > (1 << DIGIT_W) || DIGITS < 1) begin : g_bad_cfg
      $error("modn_cascade_counter: illegal parameters (MOD=%0d DIGIT_W=%0d DIGITS=%0d)",
             MOD, DIGIT_W, DIGITS);
    end
  endgenerate

  localparam logic [DIGIT_W-1:0] MAX_D = DIGIT_W'(MOD - 1);

  logic                      all_max;
  logic                      all_zero;
  logic                      hold;
  logic [DIGITS*DIGIT_W-1:0] step_q;
  logic [DIGITS*DIGIT_W-1:0] load_q;
  logic [DIGIT_W-1:0]        cur_d;
  logic [DIGIT_W-1:0]        ld_d;
  logic                      run;

  // Terminal-value detection across all digits.
  always_comb begin
    all_max  = 1'b1;
    all_zero = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      all_max  = all_max  & (q[i*DIGIT_W +: DIGIT_W] == MAX_D);
      all_zero = all_zero & (q[i*DIGIT_W +: DIGIT_W] == '0);
    end
  end

  assign tc = en & (up_dn ? all_max : all_zero);

`ifdef MODN_SAT_EN
  assign hold = sat_mode & tc;
`else
  assign hold = 1'b0;
`endif

  // Ripple carry/borrow chain: a digit steps only while every lower digit
  // sits at its rollover value for the current direction.
  always_comb begin
    step_q = q;
    run    = 1'b1;
    cur_d  = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      cur_d = q[i*DIGIT_W +: DIGIT_W];
      if (run) begin
        if (up_dn)
          step_q[i*DIGIT_W +: DIGIT_W] = (cur_d == MAX_D) ? '0 : cur_d + DIGIT_W'(1);
        else
          step_q[i*DIGIT_W +: DIGIT_W] = (cur_d == '0) ? MAX_D : cur_d - DIGIT_W'(1);
      end
      run = run & (up_dn ? (cur_d == MAX_D) : (cur_d == '0));
    end
  end

  // Per-digit clamp of the load value so no digit can reach the modulus or above.
  always_comb begin
    load_q = '0;
    ld_d   = '0;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      ld_d = load_val[i*DIGIT_W +: DIGIT_W];
      load_q[i*DIGIT_W +: DIGIT_W] = (ld_d > MAX_D) ? MAX_D : ld_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      q    <= '0;
      wrap <= 1'b0;
    end else if (load) begin
      q    <= load_q;
      wrap <= 1'b0;
    end else if (en && !hold) begin
      q    <= step_q;
      wrap <= tc;
    end else begin
      wrap <= 1'b0;
    end
  end

endmodule
